// File: rtl/dmem_sram_bridge_pkg.sv
// ============================================================================
// Module  : dmem_sram_bridge_pkg
// Brief   : Shared FSM state encoding and access-size codes for the M-stage
//           data-memory to sram-like bus bridge.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_sram_bridge_pkg;

   // Raw two-bit state codes; the enum below is built on top of them
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,   // no access outstanding
      S_REQ  = ST_REQ,    // request issued, waiting for addr_ok
      S_WAIT = ST_WAIT,   // address accepted, waiting for data_ok
      S_DONE = ST_DONE    // load result held while the pipeline is stalled
   } state_e;

   // Access-size codes carried on mem_size / data_size
   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // A nonzero byte-write mask marks a store
   function automatic logic is_store(input logic [3:0] wen);
      return |wen;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_sram_bridge_if.sv
// ============================================================================
// Module  : dmem_sram_bridge_if
// Brief   : sram-like data bus between the bridge (master) and the memory
//           side (slave).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_sram_bridge_if #(
   parameter int ADDR_W = 32
);
   logic              data_req;
   logic              data_wr;
   logic [1:0]        data_size;
   logic [ADDR_W-1:0] data_addr;
   logic [31:0]       data_wdata;
   logic              data_addr_ok;
   logic              data_data_ok;
   logic [31:0]       data_rdata;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata,
      input  data_addr_ok, data_data_ok, data_rdata
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      output data_addr_ok, data_data_ok, data_rdata
   );
endinterface

`default_nettype wire

// File: rtl/dmem_sram_bridge_addr_map.sv
// ============================================================================
// Module  : dmem_addr_map
// Brief   : Virtual-to-physical data address translation. With
//           DMEM_KSEG_MAP_EN defined, kseg0/kseg1 (addr[31:30]==2'b10) drop
//           their top three bits; otherwise the address passes through.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_addr_map #(
   parameter int ADDR_W = 32
) (
   input  wire logic [ADDR_W-1:0] vaddr,
   output logic      [ADDR_W-1:0] paddr
);

`ifdef DMEM_KSEG_MAP_EN
   generate
      if (ADDR_W >= 32) begin : g_kseg
         // Unmapped kernel segments alias the low 512 MB of physical space
         always_comb begin
            paddr = vaddr;
            if (vaddr[31:30] == 2'b10) begin
               paddr[31:29] = 3'b000;
            end
         end
      end else begin : g_narrow
         assign paddr = vaddr;
      end
   endgenerate
`else
   assign paddr = vaddr;
`endif

endmodule

`default_nettype wire

// File: rtl/dmem_sram_bridge.sv
// ============================================================================
// Module  : dmem_sram_bridge
// Brief   : Converts M-stage load/store requests into sram-like bus
//           transactions, stalling the pipeline while an access is pending.
//           Optional macro DMEM_KSEG_MAP_EN enables kseg0/kseg1 address
//           translation in dmem_addr_map.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_sram_bridge
   import dmem_sram_bridge_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  wire logic              clk,
   input  wire logic              rst,          // asynchronous, active low
   input  wire logic              mem_en,
   input  wire logic [3:0]        mem_wen,
   input  wire logic [1:0]        mem_size,
   input  wire logic [ADDR_W-1:0] mem_addr,
   input  wire logic [31:0]       mem_wdata,
   input  wire logic              except_flush,
   input  wire logic              cpu_stall,
   output logic      [31:0]       mem_rdata,
   output logic                   mem_stall,
   dmem_sram_bridge_if.master     data_bus
);

   state_e            state_q, state_d;
   logic              drop_q, drop_d;
   logic [31:0]       rdata_q;

   // Request fields captured at issue so they stay stable until addr_ok
   logic              lat_wr;
   logic [1:0]        lat_size;
   logic [ADDR_W-1:0] lat_addr;
   logic [31:0]       lat_wdata;

   logic              req_c;
   logic              stall_c;
   logic              capture_c;
   logic              latch_c;
   logic              wr_c;
   logic [1:0]        size_c;
   logic [ADDR_W-1:0] vaddr_c;
   logic [31:0]       wdata_c;
   logic [ADDR_W-1:0] paddr_c;

   // Next-state, request and stall decode
   always_comb begin
      state_d   = state_q;
      drop_d    = drop_q;
      req_c     = 1'b0;
      stall_c   = 1'b0;
      capture_c = 1'b0;
      latch_c   = 1'b0;
      wr_c      = lat_wr;
      size_c    = lat_size;
      vaddr_c   = lat_addr;
      wdata_c   = lat_wdata;

      case (state_q)
         S_IDLE: begin
            // Fields go straight from the pipeline so a fast slave can
            // accept the address in the issue cycle
            wr_c    = is_store(mem_wen);
            size_c  = mem_size;
            vaddr_c = mem_addr;
            wdata_c = mem_wdata;
            req_c   = mem_en & ~except_flush;
            stall_c = req_c;
            if (req_c) begin
               latch_c = 1'b1;
               state_d = data_bus.data_addr_ok ? S_WAIT : S_REQ;
            end
         end
         S_REQ: begin
            stall_c = 1'b1;
            if (except_flush) begin
               // Request not yet accepted: it can simply be withdrawn
               state_d = S_IDLE;
            end else begin
               req_c = 1'b1;
               if (data_bus.data_addr_ok) begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // An accepted access must complete on the bus even if flushed;
            // drop_q keeps its result out of the pipeline
            stall_c = ~data_bus.data_data_ok | drop_q;
            if (except_flush) begin
               drop_d = 1'b1;
            end
            if (data_bus.data_data_ok) begin
               drop_d = 1'b0;
               if (drop_q || except_flush) begin
                  state_d = S_IDLE;
               end else begin
                  capture_c = 1'b1;
                  state_d   = cpu_stall ? S_DONE : S_IDLE;
               end
            end
         end
         S_DONE: begin
            if (!cpu_stall) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // FSM state, drop flag and load-result register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         drop_q  <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
         if (capture_c) begin
            rdata_q <= data_bus.data_rdata;
         end
      end
   end

   // Capture the request fields whenever a new access is issued
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_wr    <= 1'b0;
         lat_size  <= 2'b00;
         lat_addr  <= '0;
         lat_wdata <= 32'h0;
      end else if (latch_c) begin
         lat_wr    <= wr_c;
         lat_size  <= size_c;
         lat_addr  <= vaddr_c;
         lat_wdata <= wdata_c;
      end
   end

   dmem_addr_map #(
      .ADDR_W (ADDR_W)
   ) u_addr_map (
      .vaddr (vaddr_c),
      .paddr (paddr_c)
   );

   // Bus outputs; request and stall are masked while reset is held so the
   // combinational IDLE path cannot leak a request out of reset
   always_comb begin
      data_bus.data_req   = req_c & rst;
      data_bus.data_wr    = wr_c;
      data_bus.data_size  = size_c;
      data_bus.data_addr  = paddr_c;
      data_bus.data_wdata = wdata_c;
      mem_stall           = stall_c & rst;
      mem_rdata           = ((state_q == S_WAIT) && data_bus.data_data_ok) ?
                            data_bus.data_rdata : rdata_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_dmem_sram_bridge.sv
// ============================================================================
// Module  : tb_dmem_sram_bridge
// Brief   : Directed self-checking bench for dmem_sram_bridge. Load results
//           are queued when data_ok is driven and popped when mem_rdata is
//           checked.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_sram_bridge;

   logic        clk;
   logic        rst;
   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        except_flush;
   logic        cpu_stall;
   logic [31:0] mem_rdata;
   logic        mem_stall;

   int          tests;
   int          fails;
   int          stall_cnt;
   int          req_cnt;
   logic [31:0] sb_q[$];
   logic [31:0] last_rd;
   logic [31:0] kseg_exp;

   dmem_sram_bridge_if #(.ADDR_W(32)) bus ();

   dmem_sram_bridge #(
      .ADDR_W (32)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_en       (mem_en),
      .mem_wen      (mem_wen),
      .mem_size     (mem_size),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .except_flush (except_flush),
      .cpu_stall    (cpu_stall),
      .mem_rdata    (mem_rdata),
      .mem_stall    (mem_stall),
      .data_bus     (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare mem_rdata against the oldest queued load result
   task automatic chk_pop(input string tag);
      logic [31:0] e;
      if (sb_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s observed=%h expected=<queued result>", tag, mem_rdata);
      end else begin
         e = sb_q.pop_front();
         last_rd = e;
         chk(tag, mem_rdata, e);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] a, input logic aok);
      mem_en = 1'b1; mem_wen = 4'b0000; mem_size = 2'd2;
      mem_addr = a; mem_wdata = 32'h0; bus.data_addr_ok = aok;
   endtask

   task automatic data_ok(input logic [31:0] d, input logic keep);
      bus.data_data_ok = 1'b1; bus.data_rdata = d;
      if (keep) sb_q.push_back(d);
   endtask

   initial begin
      tests = 0; fails = 0; last_rd = 32'h0;
      rst = 1'b0; mem_en = 1'b1; mem_wen = 4'h0; mem_size = 2'd2;
      mem_addr = 32'h4; mem_wdata = 32'h0; except_flush = 1'b0; cpu_stall = 1'b0;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;

      // Reset: outputs quiet even with mem_en asserted
      #3;
      chk("rst_req", {31'b0, bus.data_req}, 32'd0);
      chk("rst_stall", {31'b0, mem_stall}, 32'd0);
      chk("rst_rdata", mem_rdata, 32'h0);
      cyc(); cyc();
      rst = 1'b1; mem_en = 1'b0;

      // Fast load: addr_ok at issue, data_ok next cycle
      cyc(); load(32'h0000_0010, 1'b1); #2;
      stall_cnt = int'(mem_stall);
      chk("ld_req", {31'b0, bus.data_req}, 32'd1);
      chk("ld_addr", bus.data_addr, 32'h0000_0010);
      chk("ld_wr", {31'b0, bus.data_wr}, 32'd0);
      cyc(); mem_en = 1'b0; bus.data_addr_ok = 1'b0; data_ok(32'hDEAD_BEEF, 1'b1); #2;
      stall_cnt += int'(mem_stall);
      chk_pop("ld_rdata");
      cyc(); bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0; #2;
      chk("ld_stall_cycles", stall_cnt, 32'd1);
      chk("ld_hold", mem_rdata, last_rd);

      // Store with addr_ok delayed three cycles; inputs scrambled meanwhile
      cyc(); mem_en = 1'b1; mem_wen = 4'b0011; mem_size = 2'd1;
      mem_addr = 32'h0000_0100; mem_wdata = 32'hBEEF_BEEF; bus.data_addr_ok = 1'b0; #2;
      req_cnt = int'(bus.data_req);
      chk("st_wr", {31'b0, bus.data_wr}, 32'd1);
      chk("st_stall0", {31'b0, mem_stall}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         cyc(); mem_wen = 4'b0000; mem_size = 2'd0; mem_addr = $urandom;
         mem_wdata = $urandom; bus.data_addr_ok = (i == 2); #2;
         req_cnt += int'(bus.data_req);
         chk("st_hold_addr", bus.data_addr, 32'h0000_0100);
         chk("st_hold_wdata", bus.data_wdata, 32'hBEEF_BEEF);
         chk("st_hold_wr", {31'b0, bus.data_wr}, 32'd1);
         chk("st_hold_size", {30'b0, bus.data_size}, 32'd1);
         chk("st_hold_stall", {31'b0, mem_stall}, 32'd1);
      end
      cyc(); mem_en = 1'b0; bus.data_addr_ok = 1'b0; #2;
      chk("st_req_cycles", req_cnt, 32'd4);
      chk("st_wait_req", {31'b0, bus.data_req}, 32'd0);
      chk("st_wait_stall", {31'b0, mem_stall}, 32'd1);
      cyc(); data_ok(32'hCAFE_0000, 1'b1); #2;
      chk("st_done_stall", {31'b0, mem_stall}, 32'd0);
      chk_pop("st_rdata");
      cyc(); bus.data_data_ok = 1'b0;

      // Flush while in REQ: request withdrawn, stray data_ok ignored
      cyc(); load(32'h0000_0030, 1'b0); #2;
      chk("fr_req0", {31'b0, bus.data_req}, 32'd1);
      cyc(); except_flush = 1'b1; #2;
      chk("fr_req_drop", {31'b0, bus.data_req}, 32'd0);
      cyc(); except_flush = 1'b0; mem_en = 1'b0; data_ok(32'h5555_5555, 1'b0); #2;
      chk("fr_idle_stall", {31'b0, mem_stall}, 32'd0);
      chk("fr_idle_req", {31'b0, bus.data_req}, 32'd0);
      chk("fr_rdata", mem_rdata, last_rd);
      cyc(); bus.data_data_ok = 1'b0;

      // Flush while in WAIT: access completes but result is discarded
      cyc(); load(32'h0000_0040, 1'b1); #2;
      chk("fw_addr", bus.data_addr, 32'h0000_0040);
      cyc(); bus.data_addr_ok = 1'b0; mem_en = 1'b0; except_flush = 1'b1; #2;
      chk("fw_stall1", {31'b0, mem_stall}, 32'd1);
      cyc(); except_flush = 1'b0; data_ok(32'h1234_5678, 1'b0); #2;
      chk("fw_stall_dok", {31'b0, mem_stall}, 32'd1);
      cyc(); bus.data_data_ok = 1'b0; #2;
      chk("fw_stall_end", {31'b0, mem_stall}, 32'd0);
      chk("fw_rdata_kept", mem_rdata, last_rd);

      // data_ok under cpu_stall: DONE holds the result, no new request
      cyc(); load(32'h0000_0020, 1'b1); #2;
      cyc(); bus.data_addr_ok = 1'b0; cpu_stall = 1'b1; data_ok(32'hA5A5_5A5A, 1'b1); #2;
      chk("dn_stall", {31'b0, mem_stall}, 32'd0);
      chk_pop("dn_rdata");
      cyc(); bus.data_data_ok = 1'b0; mem_addr = 32'h0000_0024; #2;
      chk("dn_req1", {31'b0, bus.data_req}, 32'd0);
      chk("dn_hold1", mem_rdata, last_rd);
      cyc(); cpu_stall = 1'b0; #2;
      chk("dn_req2", {31'b0, bus.data_req}, 32'd0);
      chk("dn_hold2", mem_rdata, last_rd);
      cyc(); bus.data_addr_ok = 1'b1; #2;
      chk("b2b_req", {31'b0, bus.data_req}, 32'd1);
      chk("b2b_addr", bus.data_addr, 32'h0000_0024);
      cyc(); mem_en = 1'b0; bus.data_addr_ok = 1'b0; data_ok(32'h0BAD_F00D, 1'b1); #2;
      chk_pop("b2b_rdata");
      cyc(); bus.data_data_ok = 1'b0;

      // Address map on a kseg1 address
`ifdef DMEM_KSEG_MAP_EN
      kseg_exp = 32'h1FC0_0100;
`else
      kseg_exp = 32'hBFC0_0100;
`endif
      cyc(); load(32'hBFC0_0100, 1'b1); #2;
      chk("kseg_addr", bus.data_addr, kseg_exp);
      cyc(); mem_en = 1'b0; bus.data_addr_ok = 1'b0; data_ok(32'h1111_2222, 1'b1); #2;
      chk_pop("kseg_rdata");
      cyc(); bus.data_data_ok = 1'b0;

      // Reset in the middle of an unaccepted request
      cyc(); load(32'h0000_0050, 1'b0); #2;
      chk("mr_req0", {31'b0, bus.data_req}, 32'd1);
      cyc(); #1; rst = 1'b0; #1;
      last_rd = 32'h0;
      chk("mr_req", {31'b0, bus.data_req}, 32'd0);
      chk("mr_stall", {31'b0, mem_stall}, 32'd0);
      chk("mr_rdata", mem_rdata, last_rd);
      cyc(); rst = 1'b1; load(32'h0000_0060, 1'b1); #2;
      chk("mr_first_req", {31'b0, bus.data_req}, 32'd1);
      chk("mr_first_addr", bus.data_addr, 32'h0000_0060);
      cyc(); mem_en = 1'b0; bus.data_addr_ok = 1'b0; data_ok(32'h7777_8888, 1'b1); #2;
      chk_pop("mr_rdata_new");
      cyc(); bus.data_data_ok = 1'b0; #2;
      chk("end_idle_stall", {31'b0, mem_stall}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_sram_bridge.md
DMEM_SRAM_BRIDGE -- requirements
Module: dmem_sram_bridge

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the width of mem_addr and data_addr.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 mem_en  in  1  SHALL mark an M-stage load or store.
REQ-005 mem_wen  in  4  SHALL be the byte-write mask; nonzero means store.
REQ-006 mem_size  in  2  SHALL give the access size: 0 byte, 1 half, 2 word.
REQ-007 mem_addr  in  ADDR_W  SHALL carry the M-stage virtual address.
REQ-008 mem_wdata  in  32  SHALL carry the lane-replicated store data.
REQ-009 except_flush  in  1  SHALL flag an M-stage exception or flush.
REQ-010 cpu_stall  in  1  SHALL flag a pipeline hold from any other source.
REQ-011 mem_rdata  out  32  SHALL carry the load result to the W-stage register.
REQ-012 mem_stall  out  1  SHALL hold the pipeline while an access is outstanding.
REQ-013 data_req, data_wr  out  1 each  SHALL be the sram-like request and write flag.
REQ-014 data_size  out  2, data_addr  out  ADDR_W, data_wdata  out  32  SHALL carry the request fields.
REQ-015 data_addr_ok, data_data_ok  in  1 each, data_rdata  in  32  SHALL carry the slave handshake.

Function
REQ-016 The FSM SHALL have four states: IDLE, REQ (issued, awaiting addr_ok), WAIT (awaiting data_ok) and DONE (result held while cpu_stall is high).
REQ-017 In IDLE, data_req SHALL be mem_en & ~except_flush, combinationally, with the request fields driven directly from the mem_* inputs.
REQ-018 In IDLE, a request with addr_ok SHALL go to WAIT, and a request without addr_ok SHALL go to REQ with the fields latched.
REQ-019 In REQ, data_req SHALL be 1 with the fields from the latches, and addr_ok SHALL move the FSM to WAIT.
REQ-020 In REQ, except_flush SHALL drop data_req in the same cycle and return the FSM to IDLE with no transaction.
REQ-021 In WAIT, data_ok SHALL capture data_rdata into rdata_q and move the FSM to DONE if cpu_stall is high, otherwise to IDLE.
REQ-022 In WAIT, except_flush SHALL set drop_q; data_ok SHALL then go to IDLE without updating rdata_q, and drop_q SHALL clear.
REQ-023 DONE SHALL move to IDLE on the first cycle with ~cpu_stall, with no new request issued while in DONE.
REQ-024 mem_stall SHALL be (IDLE & data_req) | REQ | (WAIT & ~data_ok) | (WAIT & drop_q).
REQ-025 mem_rdata SHALL be data_rdata when WAIT & data_ok, and rdata_q otherwise.
REQ-026 data_wr SHALL be |mem_wen (latched in REQ), and data_size SHALL equal mem_size.
REQ-027 data_ok SHALL be ignored outside WAIT, and addr_ok SHALL be ignored when data_req is 0.
REQ-028 Minimum latency SHALL be addr_ok in the issue cycle plus data_ok one cycle later, giving 1 stall cycle.
REQ-029 A back-to-back access SHALL be issued in the cycle after the FSM returns to IDLE.

Reset
REQ-030 Reset SHALL force state IDLE and clear drop_q, rdata_q and all latches to 0.
REQ-031 During reset, data_req and mem_stall SHALL be 0 and mem_rdata SHALL be 0.
REQ-032 On reset deassertion, the FSM SHALL accept a request on the first following edge.
REQ-033 Reset mid-transaction SHALL abandon the access without waiting for data_ok.

Configuration
REQ-034 With DMEM_KSEG_MAP_EN defined, data_addr SHALL be the physical address: kseg0/kseg1 (addr[31:30]==2'b10) maps to {3'b000, addr[28:0]}, and all other addresses pass through unchanged.
REQ-035 Without DMEM_KSEG_MAP_EN, data_addr SHALL equal mem_addr unchanged.

Structure
REQ-036 The state encoding and the size codes SHALL live in the shared package, with the FSM states defined there as localparams.
REQ-037 The address mapping SHALL be one sub-module, dmem_addr_map, which becomes a pass-through when DMEM_KSEG_MAP_EN is absent.

Verification
REQ-038 Load to 0x0000_0010 with addr_ok at once, data_ok next cycle with 0xDEADBEEF -> mem_stall high 1 cycle; mem_rdata=0xDEADBEEF.
REQ-039 Store wen=4'b0011 with addr_ok delayed 3 cycles -> data_req high 4 cycles; data_wr=1; fields stable; mem_stall high until data_ok.
REQ-040 except_flush in REQ -> data_req=0 that cycle; FSM in IDLE; no data_ok expected.
REQ-041 except_flush in WAIT, data_ok with 0x12345678 -> rdata_q unchanged; mem_stall low only after data_ok.
REQ-042 data_ok while cpu_stall=1 for 2 cycles -> FSM in DONE; mem_rdata held; no request issued; IDLE after release.
REQ-043 With DMEM_KSEG_MAP_EN, load at 0xBFC0_0100 -> data_addr=0x1FC0_0100; without the macro -> 0xBFC0_0100.
